c1541_iec_frontend: RTL and testbench
=====================================

Name: c1541_iec_frontend

Overview:
- Parametrised serial-bus and clock-enable front end shared by up to NDRIVES 1541-class drive cores on one host IEC port.
- Generates per-drive phi2 rise/fall strobes from clk32, with a per-drive 1 MHz/2 MHz mode for 1571-style fast drives.
- Filters the host ATN/CLK/DATA lines and merges all drive outputs into one open-collector bus, including per-drive ATN auto-acknowledge.
- Replaces the single-drive divider, sync filter and bus glue inside each drive logic block.

Parameters:
- NDRIVES, 4, number of drive slots (1..8).
- CLK_DIV, 32, clk32 cycles per 1 MHz phi2 period; must be a multiple of 4, minimum 8.
- FILT_LEN, 2, consecutive identical samples needed before a filtered line changes (1..15).

Ports:
- clk32  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sb_atn_in  in  1  host ATN bus level; 1 = released.
- sb_clk_in  in  1  host CLK bus level; 1 = released.
- sb_data_in  in  1  host DATA bus level; 1 = released.
- drv_en  in  NDRIVES  drive slot enabled.
- drv_fast  in  NDRIVES  1 = 2 MHz phi2 for that slot.
- drv_clk_pull  in  NDRIVES  drive pulls CLK low (VIA PB3 effective level).
- drv_data_pull  in  NDRIVES  drive pulls DATA low (VIA PB1 effective level).
- drv_atna  in  NDRIVES  VIA PB4 effective level (ATN acknowledge).
- p2_h_r  out  NDRIVES  phi2 rising strobe, 1 clk32 wide.
- p2_h_f  out  NDRIVES  phi2 falling strobe, 1 clk32 wide; the CPU enable.
- iec_atn  out  1  filtered ATN level.
- iec_clk  out  1  filtered CLK level.
- iec_data  out  1  filtered DATA level.
- atn_fall  out  1  1-clk pulse when filtered ATN goes 1->0.
- sb_clk_out  out  1  merged CLK drive; 0 = pulled.
- sb_data_out  out  1  merged DATA drive; 0 = pulled.
- bus_clk  out  1  iec_clk & sb_clk_out; the drive-side view of the wire.
- bus_data  out  1  iec_data & sb_data_out.

Behaviour:
- Reset, asynchronous:
  - divider = 0; filter counters = 0.
  - iec_atn, iec_clk, iec_data = 1.
  - atn_fall, p2_h_r, p2_h_f = 0.
  - en_q and fast_q = 0, so the bus is released: sb_clk_out = sb_data_out = 1.
- Divider:
  - Free-running 0..CLK_DIV-1, wraps to 0.
  - Width is $clog2(CLK_DIV).
- Strobes are registered, so each is asserted in the clk32 cycle after the divider value that triggers it:
  - Slow slot: p2_h_r at divider 0; p2_h_f at CLK_DIV/2.
  - Fast slot: p2_h_r at 0 and CLK_DIV/2; p2_h_f at CLK_DIV/4 and 3*CLK_DIV/4.
  - Disabled slot (en_q = 0): no strobes.
- Mode and enable latching:
  - drv_en and drv_fast are sampled into en_q/fast_q only when divider = CLK_DIV-1.
  - This guarantees no runt or merged phi2 cycles.
  - Changes at any other time are deferred to the next wrap.
- Filter (one instance per line):
  - 2-flop synchroniser, then a counter.
  - The counter increments while the synchronised sample differs from the output; otherwise it clears.
  - When the counter reaches FILT_LEN, the output takes the sample and the counter clears.
  - Latency from input edge to output: 2+FILT_LEN clk32.
  - A pulse shorter than FILT_LEN samples is never passed.
- atn_fall: registered, asserted the cycle after iec_atn goes 1->0.
- Merge logic, combinational, zero latency; for each slot i with en_q[i] = 1:
  - clk pull: drv_clk_pull[i].
  - data pull: drv_data_pull[i] | (drv_atna[i] ^ ~sb_atn_in).
  - ATN ack uses raw sb_atn_in, not the filtered value, so the acknowledge meets the host timing.
  - sb_clk_out = ~OR(clk pulls); sb_data_out = ~OR(data pulls).
  - Disabled slots contribute no pulls.
- Simultaneous events:
  - Enable and fast changing together both latch at the same wrap.
  - A filter input toggling back before FILT_LEN clears the counter; the output is unchanged.

Decomposition:
- Package c1541_pkg:
  - IEC_RELEASED = 1'b1.
  - DEFAULT_CLK_DIV = 32.
  - DEFAULT_FILT_LEN = 2.
  - MAX_DRIVES = 8.
- Sub-module iec_line_filter (synchroniser + counter; parameter FILT_LEN; output reset value 1), instantiated three times.

Test Plan:
- Reset release with NDRIVES=2, CLK_DIV=32, drv_en=2'b01, drv_fast=0:
  - Slot0 p2_h_f pulses every 32 clk32, 16 after p2_h_r.
  - Slot1 emits no strobes.
  - sb outputs stay 1.
- Set drv_fast[0]=1 mid-period at divider 10:
  - Period unchanged until wrap.
  - Afterwards p2_h_f every 16 clk32, at divider 8 and 24 (+1 register cycle).
- sb_clk_in 1-clk32 glitch low:
  - iec_clk stays 1.
- sb_clk_in low for 10 clk32:
  - iec_clk falls exactly 4 clk32 after the input edge (FILT_LEN=2).
- sb_atn_in=0 with drv_atna[0]=0, slot enabled:
  - sb_data_out=0 in the same cycle.
  - Set drv_atna[0]=1: sb_data_out returns to 1.
  - atn_fall pulses once, 5 clk32 after the ATN edge.
- Two enabled slots, slot1 drv_clk_pull=1, then drv_en[1]=0:
  - sb_clk_out=0 until the next divider wrap, then 1.
- Assert reset mid-period with the bus pulled:
  - All strobes drop and sb_clk_out/sb_data_out go to 1 with no clock edge required.

Source files
------------

// File: rtl/c1541_iec_frontend_pkg.sv
// Shared constants for the multi-drive IEC front end.
package c1541_pkg;

    // Open-collector bus level when nobody pulls the line.
    localparam logic IEC_RELEASED     = 1'b1;

    // clk32 cycles per 1 MHz phi2 period.
    localparam int   DEFAULT_CLK_DIV  = 32;

    // Consecutive identical samples before a filtered line follows its input.
    localparam int   DEFAULT_FILT_LEN = 2;

    // Largest number of drive slots one host port can serve.
    localparam int   MAX_DRIVES       = 8;

endpackage

// File: rtl/c1541_iec_frontend_line_filter.sv
// IEC line filter: 2-flop synchroniser followed by a stability counter.
// The output only follows the input after FILT_LEN consecutive differing
// samples, so pulses shorter than that never reach the drive cores.
module iec_line_filter
    import c1541_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic clk32,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw line, then count samples that disagree with the output.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sync_1   <= IEC_RELEASED;
            sync_2   <= IEC_RELEASED;
            line_out <= IEC_RELEASED;
            cnt      <= '0;
        end else begin
            sync_1 <= line_in;
            sync_2 <= sync_1;
            if (sync_2 != line_out) begin
                if (cnt == CNT_W'(FILT_LEN - 1)) begin
                    line_out <= sync_2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/c1541_iec_frontend.sv
// Shared IEC front end for up to NDRIVES drive cores: phi2 strobe
// generation with per-slot 1/2 MHz mode, host line filtering, and the
// open-collector merge of all drive outputs including ATN auto-acknowledge.
module c1541_iec_frontend
    import c1541_pkg::*;
#(
    parameter int NDRIVES  = 4,
    parameter int CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic               clk32,
    input  logic               reset,
    input  logic               sb_atn_in,
    input  logic               sb_clk_in,
    input  logic               sb_data_in,
    input  logic [NDRIVES-1:0] drv_en,
    input  logic [NDRIVES-1:0] drv_fast,
    input  logic [NDRIVES-1:0] drv_clk_pull,
    input  logic [NDRIVES-1:0] drv_data_pull,
    input  logic [NDRIVES-1:0] drv_atna,
    output logic [NDRIVES-1:0] p2_h_r,
    output logic [NDRIVES-1:0] p2_h_f,
    output logic               iec_atn,
    output logic               iec_clk,
    output logic               iec_data,
    output logic               atn_fall,
    output logic               sb_clk_out,
    output logic               sb_data_out,
    output logic               bus_clk,
    output logic               bus_data
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_Q1   = DIV_W'(CLK_DIV / 4);
    localparam logic [DIV_W-1:0] DIV_Q3   = DIV_W'((3 * CLK_DIV) / 4);

    // Reject parameter sets the divider and slot logic cannot honour.
    if (NDRIVES < 1 || NDRIVES > MAX_DRIVES) begin : g_bad_ndrives
        $error("c1541_iec_frontend: NDRIVES out of range");
    end
    if (CLK_DIV < 8 || (CLK_DIV % 4) != 0) begin : g_bad_clk_div
        $error("c1541_iec_frontend: CLK_DIV must be a multiple of 4, >= 8");
    end

    logic [DIV_W-1:0]   div;
    logic [NDRIVES-1:0] en_q;
    logic [NDRIVES-1:0] fast_q;
    logic               atn_q;
    logic               at_zero;
    logic               at_half;
    logic               at_q1;
    logic               at_q3;
    logic               clk_pull;
    logic               data_pull;

    assign at_zero = (div == '0);
    assign at_half = (div == DIV_HALF);
    assign at_q1   = (div == DIV_Q1);
    assign at_q3   = (div == DIV_Q3);

    // Free-running phi2 divider shared by every slot.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Enable and speed only change at the wrap so no slot sees a runt phi2 cycle.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            en_q   <= '0;
            fast_q <= '0;
        end else if (div == DIV_LAST) begin
            en_q   <= drv_en;
            fast_q <= drv_fast;
        end
    end

    // Registered phi2 edge strobes; fast slots get a second pair per period.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            p2_h_r <= '0;
            p2_h_f <= '0;
        end else begin
            for (int i = 0; i < NDRIVES; i++) begin
                p2_h_r[i] <= en_q[i] & (at_zero | (fast_q[i] & at_half));
                p2_h_f[i] <= en_q[i] & (fast_q[i] ? (at_q1 | at_q3) : at_half);
            end
        end
    end

    iec_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_atn (
        .clk32    (clk32),
        .reset    (reset),
        .line_in  (sb_atn_in),
        .line_out (iec_atn)
    );

    iec_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (
        .clk32    (clk32),
        .reset    (reset),
        .line_in  (sb_clk_in),
        .line_out (iec_clk)
    );

    iec_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_data (
        .clk32    (clk32),
        .reset    (reset),
        .line_in  (sb_data_in),
        .line_out (iec_data)
    );

    // One-cycle pulse after the filtered ATN line falls.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            atn_q    <= IEC_RELEASED;
            atn_fall <= 1'b0;
        end else begin
            atn_q    <= iec_atn;
            atn_fall <= atn_q & ~iec_atn;
        end
    end

    // Wired-OR of all enabled slots; ATN ack uses the raw line for host timing.
    always_comb begin
        clk_pull  = 1'b0;
        data_pull = 1'b0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (en_q[i]) begin
                clk_pull  = clk_pull | drv_clk_pull[i];
                data_pull = data_pull | drv_data_pull[i] | (drv_atna[i] ^ ~sb_atn_in);
            end
        end
    end

    assign sb_clk_out  = ~clk_pull;
    assign sb_data_out = ~data_pull;
    assign bus_clk     = iec_clk & sb_clk_out;
    assign bus_data    = iec_data & sb_data_out;

endmodule

// File: tb/tb_c1541_iec_frontend.sv
// Directed bench for c1541_iec_frontend with NDRIVES=2, CLK_DIV=32, FILT_LEN=2.
module tb_c1541_iec_frontend;

    logic       clk32 = 1'b0;
    logic       reset;
    logic       sb_atn_in;
    logic       sb_clk_in;
    logic       sb_data_in;
    logic [1:0] drv_en;
    logic [1:0] drv_fast;
    logic [1:0] drv_clk_pull;
    logic [1:0] drv_data_pull;
    logic [1:0] drv_atna;
    logic [1:0] p2_h_r;
    logic [1:0] p2_h_f;
    logic       iec_atn;
    logic       iec_clk;
    logic       iec_data;
    logic       atn_fall;
    logic       sb_clk_out;
    logic       sb_data_out;
    logic       bus_clk;
    logic       bus_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected clk32 edge numbers (counted from reset release) of slot0 strobes.
    logic [15:0] exp_r_q[$];
    logic [15:0] exp_f_q[$];

    c1541_iec_frontend #(
        .NDRIVES  (2),
        .CLK_DIV  (32),
        .FILT_LEN (2)
    ) dut (
        .clk32         (clk32),
        .reset         (reset),
        .sb_atn_in     (sb_atn_in),
        .sb_clk_in     (sb_clk_in),
        .sb_data_in    (sb_data_in),
        .drv_en        (drv_en),
        .drv_fast      (drv_fast),
        .drv_clk_pull  (drv_clk_pull),
        .drv_data_pull (drv_data_pull),
        .drv_atna      (drv_atna),
        .p2_h_r        (p2_h_r),
        .p2_h_f        (p2_h_f),
        .iec_atn       (iec_atn),
        .iec_clk       (iec_clk),
        .iec_data      (iec_data),
        .atn_fall      (atn_fall),
        .sb_clk_out    (sb_clk_out),
        .sb_data_out   (sb_data_out),
        .bus_clk       (bus_clk),
        .bus_data      (bus_data)
    );

    // Clock: 10 time-unit clk32 period.
    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clk32 edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk32);
        #1;
        cyc++;
    endtask

    // Tick until the bench's own edge count says the divider holds d.
    task automatic wait_div(input int d);
        int n;
        for (n = 0; n < 40; n++) begin
            tick();
            if ((cyc % 32) == d) break;
        end
        chk("wait_div_bound", ((n < 40) ? 32'd1 : 32'd0), 32'd1);
    endtask

    // Run to edge 'upto', scoring slot0 strobes against the queues each cycle.
    task automatic run_window(input int upto);
        logic er;
        logic ef;
        while (cyc < upto) begin
            tick();
            er = 1'b0;
            ef = 1'b0;
            if (exp_r_q.size() != 0 && exp_r_q[0] == 16'(cyc)) begin
                er = 1'b1;
                void'(exp_r_q.pop_front());
            end
            if (exp_f_q.size() != 0 && exp_f_q[0] == 16'(cyc)) begin
                ef = 1'b1;
                void'(exp_f_q.pop_front());
            end
            chk($sformatf("slot0_strobes@%0d", cyc), {30'd0, p2_h_r[0], p2_h_f[0]}, {30'd0, er, ef});
            chk($sformatf("slot1_quiet@%0d", cyc), {30'd0, p2_h_r[1], p2_h_f[1]}, 32'd0);
            chk($sformatf("sb_released@%0d", cyc), {30'd0, sb_clk_out, sb_data_out}, 32'd3);
        end
    endtask

    initial begin
        // Reset with slot0 enabled at 1 MHz, slot1 disabled, bus idle.
        reset         = 1'b1;
        sb_atn_in     = 1'b1;
        sb_clk_in     = 1'b1;
        sb_data_in    = 1'b1;
        drv_en        = 2'b01;
        drv_fast      = 2'b00;
        drv_clk_pull  = 2'b00;
        drv_data_pull = 2'b00;
        drv_atna      = 2'b00;
        #23;
        chk("rst_p2_h_r", p2_h_r, 2'b00);
        chk("rst_p2_h_f", p2_h_f, 2'b00);
        chk("rst_iec", {iec_atn, iec_clk, iec_data}, 3'b111);
        chk("rst_atn_fall", atn_fall, 1'b0);
        chk("rst_sb", {sb_clk_out, sb_data_out}, 2'b11);
        @(negedge clk32);
        reset = 1'b0;
        cyc   = 0;

        // Slow period: enable latches at edge 32, r at div 0, f at div 16.
        exp_r_q = '{16'd33, 16'd65, 16'd97};
        exp_f_q = '{16'd49, 16'd81};
        run_window(106);

        // Divider is 10: fast request waits for the wrap at edge 128.
        drv_fast = 2'b01;
        exp_r_q  = '{16'd129, 16'd145, 16'd161, 16'd177};
        exp_f_q  = '{16'd113, 16'd137, 16'd153, 16'd169, 16'd185};
        run_window(190);
        chk("r_queue_drained", exp_r_q.size(), 0);
        chk("f_queue_drained", exp_f_q.size(), 0);

        // Single-sample glitch on CLK must not pass the filter.
        sb_clk_in = 1'b0;
        tick();
        sb_clk_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch_iec_clk", iec_clk, 1'b1);
        end

        // Long CLK low: filtered output falls exactly 4 edges later.
        sb_clk_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("clk_fall_t%0d", k), iec_clk, (k >= 4) ? 1'b0 : 1'b1);
        end
        chk("bus_clk_low", bus_clk, 1'b0);
        sb_clk_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("clk_rise_t%0d", k), iec_clk, (k >= 4) ? 1'b1 : 1'b0);
        end

        // A disabled slot's data pull must not reach the bus.
        drv_data_pull = 2'b10;
        #1;
        chk("disabled_data_pull", sb_data_out, 1'b1);
        drv_data_pull = 2'b00;

        // ATN asserted with no acknowledge: DATA pulled in the same cycle.
        sb_atn_in = 1'b0;
        #1;
        chk("atn_ack_pull", sb_data_out, 1'b0);
        chk("atn_bus_data", bus_data, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("atn_fall_t%0d", k), atn_fall, (k == 5) ? 1'b1 : 1'b0);
            if (k == 4) chk("iec_atn_low", iec_atn, 1'b0);
        end
        drv_atna = 2'b01;
        #1;
        chk("atna_release", sb_data_out, 1'b1);
        sb_atn_in = 1'b1;
        drv_atna  = 2'b00;
        #1;
        chk("atn_idle_release", sb_data_out, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        chk("iec_atn_back", iec_atn, 1'b1);

        // Both slots enabled; slot1 pulls CLK and is then disabled mid-period.
        drv_en = 2'b11;
        wait_div(0);
        tick();
        chk("both_slots_rise", p2_h_r, 2'b11);
        drv_clk_pull = 2'b10;
        #1;
        chk("slot1_clk_pull", sb_clk_out, 1'b0);
        wait_div(5);
        drv_en = 2'b01;
        for (int n = 0; n < 40; n++) begin
            tick();
            if ((cyc % 32) == 0) break;
            chk("clk_pull_held", sb_clk_out, 1'b0);
        end
        chk("clk_release_at_wrap", sb_clk_out, 1'b1);
        drv_clk_pull = 2'b00;

        // Reset while slot0 pulls both lines and a strobe is high.
        drv_clk_pull  = 2'b01;
        drv_data_pull = 2'b01;
        #1;
        chk("pulled_before_rst", {sb_clk_out, sb_data_out}, 2'b00);
        wait_div(1);
        chk("strobe_before_rst", p2_h_r[0], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_r", p2_h_r, 2'b00);
        chk("async_rst_f", p2_h_f, 2'b00);
        chk("async_rst_sb", {sb_clk_out, sb_data_out}, 2'b11);
        chk("async_rst_iec", {iec_atn, iec_clk, iec_data}, 3'b111);
        #20;
        @(negedge clk32);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
